// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit restoring radix-2 divider, signed or unsigned per operand.
//
// A request is accepted in IDLE. The block then runs 32 DIV cycles (one
// quotient bit each) and one FIX cycle (sign correction), and holds the
// result in DONE until the consumer takes it. Every divide takes the same
// number of cycles, whatever the operand values.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE. resp_valid is 1 only in DONE.
// resp_result does not change while resp_valid=1 and resp_ready=0.
//
// Ports
//   clk             single clock, rising edge
//   reset           asynchronous, active-low reset
//   req_valid       request strobe
//   req_ready       block is idle and can take a request
//   req_in_1_signed dividend is two's-complement
//   req_in_2_signed divisor is two's-complement
//   req_in_1        dividend [31:0]
//   req_in_2        divisor  [31:0]
//   resp_valid      resp_result holds a completed result
//   resp_ready      consumer takes the result
//   resp_result     {remainder[31:0], quotient[31:0]}
//   state_dbg       current FSM state (0 IDLE, 1 DIV, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module div (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_in_1_signed,
   input  logic        req_in_2_signed,
   input  logic [31:0] req_in_1,
   input  logic [31:0] req_in_2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_result,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        neg_1;     // dividend is signed and negative
   logic        neg_2;     // divisor is signed and negative
   logic        dvs_zero;  // divisor was zero
   logic [31:0] dvs;       // divisor magnitude
   logic [31:0] rem;       // partial remainder
   logic [31:0] quo;       // holds dividend bits (shifting out) and quotient bits (shifting in)
   logic [4:0]  cnt;       // iteration counter
   logic [63:0] result;

   logic        accept;
   logic        in_neg_1;
   logic        in_neg_2;
   logic [31:0] mag_1;
   logic [31:0] mag_2;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign accept   = (state == IDLE) && req_valid;
   assign in_neg_1 = req_in_1_signed & req_in_1[31];
   assign in_neg_2 = req_in_2_signed & req_in_2[31];
   assign mag_1    = in_neg_1 ? -req_in_1 : req_in_1;
   assign mag_2    = in_neg_2 ? -req_in_2 : req_in_2;

   // The partial remainder is always below the divisor. So the shifted value
   // fits in 33 bits, and a successful subtract leaves a 32-bit remainder.
   assign shifted  = {rem, quo[31]};
   assign diff     = shifted - {1'b0, dvs};

   // With a zero divisor, every step subtracts successfully. This gives an
   // all-ones quotient and |dividend| as remainder. The remainder sign fix
   // below then restores the original dividend. The quotient is left
   // un-negated in that case.
   assign quo_fix  = ((neg_1 ^ neg_2) && !dvs_zero) ? -quo : quo;
   assign rem_fix  = neg_1 ? -rem : rem;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = DIV;
            end
         end
         DIV: begin
            if (cnt == 5'd0) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         neg_1    <= 1'b0;
         neg_2    <= 1'b0;
         dvs_zero <= 1'b0;
         dvs      <= 32'd0;
         rem      <= 32'd0;
         quo      <= 32'd0;
         cnt      <= 5'd0;
         result   <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  neg_1    <= in_neg_1;
                  neg_2    <= in_neg_2;
                  dvs_zero <= (req_in_2 == 32'd0);
                  dvs      <= mag_2;
                  rem      <= 32'd0;
                  quo      <= mag_1;
                  cnt      <= 5'd31;
               end
            end
            DIV: begin
               if (!diff[32]) begin
                  rem <= diff[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= shifted[31:0];
                  quo <= {quo[30:0], 1'b0};
               end
               cnt <= cnt - 5'd1;
            end
            FIX: begin
               result <= {rem_fix, quo_fix};
            end
            default: begin
            end
         endcase
      end
   end

   assign resp_result = result;
   assign state_dbg   = state;

endmodule
